// File: rtl/c5315_harness_pkg.sv
// Shared widths, byte counts and state encoding for the c5315 byte-stream vector harness.
package c5315_harness_pkg;

  localparam int IN_W_DEF  = 178;
  localparam int OUT_W_DEF = 123;

  localparam int IN_BYTES  = (IN_W_DEF + 7) / 8;
  localparam int OUT_BYTES = (OUT_W_DEF + 7) / 8;

  localparam int IN_IDX_W  = $clog2(IN_BYTES);
  localparam int OUT_IDX_W = $clog2(OUT_BYTES);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    UNLOAD = 2'd2
  } harness_state_t;

endpackage

// File: rtl/c5315_vector_harness.sv
// Deserializes a stimulus vector for the c5315 wrapper, waits a settle window,
// captures the wrapper response and streams it back out byte by byte.
module c5315_vector_harness
  import c5315_harness_pkg::*;
#(
  parameter int IN_W          = IN_W_DEF,
  parameter int OUT_W         = OUT_W_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  output logic [IN_W-1:0]  vec_out,
  input  logic [OUT_W-1:0] resp_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             busy,
  output logic [15:0]      vec_count
);

  localparam int IN_B      = (IN_W + 7) / 8;
  localparam int OUT_B     = (OUT_W + 7) / 8;
  localparam int LAST_BITS = IN_W - 8 * (IN_B - 1);
  localparam int SH_W      = 8 * (IN_B - 1);
  localparam int RESP_W    = 8 * OUT_B;
  localparam int IIW       = (IN_B > 1) ? $clog2(IN_B) : 1;
  localparam int OIW       = (OUT_B > 1) ? $clog2(OUT_B) : 1;
  localparam int CW        = $clog2(SETTLE_CYCLES + 1);

  localparam logic [IIW-1:0] IN_LAST  = IIW'(IN_B - 1);
  localparam logic [OIW-1:0] OUT_LAST = OIW'(OUT_B - 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE_CYCLES - 1);

  harness_state_t    state_q, state_d;
  logic [IIW-1:0]    in_idx_q, in_idx_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [IN_W-1:0]   vec_q, vec_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic [OIW-1:0]    out_idx_q, out_idx_d;
  logic [15:0]       vec_count_q, vec_count_d;

  always_comb begin
    state_d     = state_q;
    in_idx_d    = in_idx_q;
    shadow_d    = shadow_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    resp_d      = resp_q;
    out_idx_d   = out_idx_q;
    vec_count_d = vec_count_q;
    unique case (state_q)
      LOAD: begin
        if (s_valid) begin
          // Final byte carries only the top bits; the whole vector lands at once.
          if (in_idx_q == IN_LAST) begin
            vec_d    = {s_data[LAST_BITS-1:0], shadow_q};
            cnt_d    = '0;
            in_idx_d = '0;
            state_d  = SETTLE;
          end else begin
            shadow_d[8*in_idx_q +: 8] = s_data;
            in_idx_d = in_idx_q + 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          resp_d            = '0;
          resp_d[OUT_W-1:0] = resp_in;
          out_idx_d         = '0;
          state_d           = UNLOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      UNLOAD: begin
        if (m_ready) begin
          if (out_idx_q == OUT_LAST) begin
            vec_count_d = vec_count_q + 16'd1;
            state_d     = LOAD;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      in_idx_q    <= '0;
      shadow_q    <= '0;
      vec_q       <= '0;
      cnt_q       <= '0;
      resp_q      <= '0;
      out_idx_q   <= '0;
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      in_idx_q    <= in_idx_d;
      shadow_q    <= shadow_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      resp_q      <= resp_d;
      out_idx_q   <= out_idx_d;
      vec_count_q <= vec_count_d;
    end
  end

  // Outputs decode registered state only, so handshake inputs never reach them combinationally.
  always_comb begin
    m_data = '0;
    m_last = 1'b0;
    if (state_q == UNLOAD) begin
      m_data = resp_q[8*out_idx_q +: 8];
      m_last = (out_idx_q == OUT_LAST);
    end
  end

  assign s_ready   = (state_q == LOAD);
  assign m_valid   = (state_q == UNLOAD);
  assign busy      = (state_q != LOAD);
  assign vec_out   = vec_q;
  assign vec_count = vec_count_q;

endmodule

// File: tb/tb_c5315_vector_harness.sv
// Bench for the c5315 vector harness: two instances (settle 4 and settle 1) share stimulus
// and are checked every cycle against a transaction-level model.
module tb_c5315_vector_harness;

  localparam int IN_W  = 178;
  localparam int OUT_W = 123;
  localparam int SET0  = 4;
  localparam int SET1  = 1;

  logic             clk;
  logic             rst_n;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             m_ready;
  logic [OUT_W-1:0] resp_in;

  logic             s_ready_w   [2];
  logic [IN_W-1:0]  vec_w       [2];
  logic             m_valid_w   [2];
  logic [7:0]       m_data_w    [2];
  logic             m_last_w    [2];
  logic             busy_w      [2];
  logic [15:0]      vc_w        [2];

  int checks = 0;
  int errors = 0;

  logic             resp_rand = 1'b0;
  logic [OUT_W-1:0] resp_const = '0;

  logic [7:0]  got_b [16];
  logic [15:0] lastmask;
  logic [7:0]  vb [23];

  int              ph   [2];
  int              got  [2];
  int              wt   [2];
  int              sent [2];
  logic [7:0]      bufm [2][23];
  logic [IN_W-1:0] ev   [2];
  logic [127:0]    er   [2];
  logic [15:0]     ecnt [2];

  c5315_vector_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(SET0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w[0]), .s_data(s_data),
    .vec_out(vec_w[0]), .resp_in(resp_in), .m_valid(m_valid_w[0]), .m_ready(m_ready),
    .m_data(m_data_w[0]), .m_last(m_last_w[0]), .busy(busy_w[0]), .vec_count(vc_w[0])
  );

  c5315_vector_harness #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(SET1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_w[1]), .s_data(s_data),
    .vec_out(vec_w[1]), .resp_in(resp_in), .m_valid(m_valid_w[1]), .m_ready(m_ready),
    .m_data(m_data_w[1]), .m_last(m_last_w[1]), .busy(busy_w[1]), .vec_count(vc_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Response driver: constant pattern or a fresh random word every cycle.
  initial begin
    resp_in = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_in = resp_rand ? OUT_W'({$urandom, $urandom, $urandom, $urandom}) : resp_const;
    end
  end

  // Transaction model: counts bytes in, settle cycles, bytes out.
  initial begin
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; got[d] = 0; wt[d] = 0; sent[d] = 0; ev[d] = '0; er[d] = '0; ecnt[d] = '0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n) begin
          ph[d] = 0; got[d] = 0; wt[d] = 0; sent[d] = 0; ev[d] = '0; er[d] = '0; ecnt[d] = '0;
        end else if (ph[d] == 0) begin
          if (s_valid) begin
            bufm[d][got[d]] = s_data;
            got[d]++;
            if (got[d] == 23) begin
              for (int b = 0; b < IN_W; b++) ev[d][b] = bufm[d][b/8][b%8];
              ph[d] = 1;
              wt[d] = 0;
            end
          end
        end else if (ph[d] == 1) begin
          wt[d]++;
          if (wt[d] == ((d == 0) ? SET0 : SET1)) begin
            er[d]   = {5'b0, resp_in};
            ph[d]   = 2;
            sent[d] = 0;
          end
        end else begin
          if (m_ready) begin
            sent[d]++;
            if (sent[d] == 16) begin
              ecnt[d] = ecnt[d] + 16'd1;
              ph[d]   = 0;
              got[d]  = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic [7:0] eb;
        eb = (ph[d] == 2) ? 8'(er[d] >> (8 * sent[d])) : 8'h00;
        chk($sformatf("d%0d_s_ready", d), 256'(s_ready_w[d]), 256'(ph[d] == 0));
        chk($sformatf("d%0d_m_valid", d), 256'(m_valid_w[d]), 256'(ph[d] == 2));
        chk($sformatf("d%0d_busy", d), 256'(busy_w[d]), 256'(ph[d] != 0));
        chk($sformatf("d%0d_vec_out", d), 256'(vec_w[d]), 256'(ev[d]));
        chk($sformatf("d%0d_vec_count", d), 256'(vc_w[d]), 256'(ecnt[d]));
        chk($sformatf("d%0d_m_data", d), 256'(m_data_w[d]), 256'(eb));
        chk($sformatf("d%0d_m_last", d), 256'(m_last_w[d]), 256'((ph[d] == 2) && (sent[d] == 15)));
      end
    end
  end

  task automatic load_vec(input logic [7:0] b [23], input int gap);
    int   k = 0;
    int   guard = 0;
    logic acc;
    while (k < 23 && guard < 3000) begin
      s_data  = b[k];
      s_valid = (int'($urandom_range(99)) >= gap) && s_ready_w[0] && s_ready_w[1];
      acc     = s_valid;
      @(posedge clk);
      #1;
      if (acc) k++;
      guard++;
    end
    s_valid = 1'b0;
    if (k < 23) chk("load_timeout", 256'(k), 256'(23));
  endtask

  task automatic drain(input int rdy, input int stop_n, output int n);
    int guard = 0;
    n = 0;
    lastmask = '0;
    while (!(s_ready_w[0] && s_ready_w[1]) && n < stop_n && guard < 3000) begin
      m_ready = int'($urandom_range(99)) < rdy;
      @(negedge clk);
      if (m_valid_w[0] && m_ready) begin
        got_b[n]    = m_data_w[0];
        lastmask[n] = m_last_w[0];
        n++;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    m_ready = 1'b0;
    if (guard >= 3000) chk("drain_timeout", 256'(guard), 256'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    logic [127:0] pat;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", 256'(s_ready_w[0]), 256'(1));
    chk("rst_m_valid", 256'(m_valid_w[0]), 256'(0));
    chk("rst_m_data", 256'(m_data_w[0]), 256'(0));
    chk("rst_m_last", 256'(m_last_w[0]), 256'(0));
    chk("rst_busy", 256'(busy_w[0]), 256'(0));
    chk("rst_vec_out", 256'(vec_w[0]), 256'(0));
    chk("rst_vec_count", 256'(vc_w[0]), 256'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_s_ready", 256'(s_ready_w[0]), 256'(1));
    chk("rel_busy", 256'(busy_w[0]), 256'(0));

    // All-ones vector, zero response.
    resp_const = '0;
    for (int i = 0; i < 23; i++) vb[i] = 8'hFF;
    load_vec(vb, 0);
    chk("ones_vec_out", 256'(vec_w[0]), 256'({IN_W{1'b1}}));
    drain(100, 16, n);
    chk("ones_nbytes", 256'(n), 256'(16));
    for (int i = 0; i < 16; i++) chk($sformatf("ones_byte%0d", i), 256'(got_b[i]), 256'(0));
    chk("ones_lastmask", 256'(lastmask), 256'(16'h8000));
    chk("ones_vec_count", 256'(vc_w[0]), 256'(1));

    // Ordering: byte k = k, response 0x5A pattern.
    pat = {16{8'h5A}};
    resp_const = pat[OUT_W-1:0];
    for (int i = 0; i < 23; i++) vb[i] = 8'(i);
    load_vec(vb, 0);
    chk("ord_byte0", 256'(vec_w[0][7:0]), 256'(8'h00));
    chk("ord_byte1", 256'(vec_w[0][15:8]), 256'(8'h01));
    chk("ord_top", 256'(vec_w[0][177:176]), 256'(2'b10));
    drain(100, 16, n);
    chk("ord_resp0", 256'(got_b[0]), 256'(8'h5A));
    chk("ord_resp7", 256'(got_b[7]), 256'(8'h5A));
    chk("ord_resp15", 256'(got_b[15]), 256'(8'h02));
    chk("ord_vec_count", 256'(vc_w[0]), 256'(2));

    // Random vectors, per-cycle response changes, gaps and backpressure.
    resp_rand = 1'b1;
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 23; i++) vb[i] = 8'($urandom);
      load_vec(vb, 30);
      drain(50, 16, n);
      chk("rnd_nbytes", 256'(n), 256'(16));
    end
    chk("rnd_vec_count0", 256'(vc_w[0]), 256'(8));
    chk("rnd_vec_count1", 256'(vc_w[1]), 256'(8));

    // Reset after 7 response bytes.
    for (int i = 0; i < 23; i++) vb[i] = 8'($urandom);
    load_vec(vb, 10);
    drain(60, 7, n);
    chk("mid_nbytes", 256'(n), 256'(7));
    rst_n = 1'b0;
    #1;
    chk("mid_m_valid", 256'(m_valid_w[0]), 256'(0));
    chk("mid_vec_out", 256'(vec_w[0]), 256'(0));
    chk("mid_s_ready", 256'(s_ready_w[0]), 256'(1));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) vb[i] = 8'($urandom);
    load_vec(vb, 20);
    chk("post_vec_byte0", 256'(vec_w[0][7:0]), 256'(vb[0]));
    drain(100, 16, n);
    chk("post_vec_count0", 256'(vc_w[0]), 256'(1));
    chk("post_vec_count1", 256'(vc_w[1]), 256'(1));

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c5315_vector_harness.md
# c5315_vector_harness

Byte-stream test harness for the c5315 wrapper, which has a 178-bit `in_val` and a 123-bit `out_val`.
- Deserializes a byte stream into a stable 178-bit stimulus vector and drives it onto the wrapper input.
- Waits a fixed settle window, then captures the 123-bit wrapper response.
- Serializes the response back out as bytes.
- Sits between the host/UART link and the wrapper; serves golden-vs-suspect response collection for Trojan detection.

## Interface
Parameters:
- `IN_W`, 178, stimulus width (wrapper `in_val`)
- `OUT_W`, 123, response width (wrapper `out_val`)
- `SETTLE_CYCLES`, 4, cycles between vector update and response capture; legal range ≥1

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `s_valid`  in  1  stimulus byte valid
- `s_ready`  out  1  harness accepts stimulus byte
- `s_data`  in  8  stimulus byte
- `vec_out`  out  IN_W  stimulus to wrapper `in_val`
- `resp_in`  in  OUT_W  response from wrapper `out_val`
- `m_valid`  out  1  response byte valid
- `m_ready`  in  1  downstream accepts response byte
- `m_data`  out  8  response byte
- `m_last`  out  1  final response byte of a vector
- `busy`  out  1  high in SETTLE and UNLOAD
- `vec_count`  out  16  completed vectors, wraps at 0xFFFF→0

## Operation
- Byte counts: IN_BYTES = ceil(IN_W/8) = 23; OUT_BYTES = ceil(OUT_W/8) = 16.
- States: LOAD, SETTLE, UNLOAD. Reset state is LOAD.
- LOAD:
  - `s_ready`=1; a byte transfers on `s_valid`&&`s_ready`.
  - Bytes are little-endian: byte k fills bits [8k+7:8k] of a shadow register.
  - Byte 22 contributes only bits [1:0] (bits 177:176); its bits [7:2] are discarded.
  - Accepting byte 22 copies shadow plus final bits to `vec_out`, clears the settle counter, and enters SETTLE.
- `vec_out` changes only on that copy. It holds during the next LOAD, so the wrapper sees a stable vector.
- SETTLE:
  - `s_ready`=0; counter increments each cycle.
  - At the edge where counter == SETTLE_CYCLES-1: capture `resp_in` into the output shift register (upper 5 pad bits = 0), clear the byte index, enter UNLOAD.
- UNLOAD:
  - `m_valid`=1; `m_data` = response bits [8i+7:8i] for byte index i.
  - On `m_valid`&&`m_ready`, advance i.
  - `m_last`=1 when i=15; byte 15 carries bits [122:120] in [2:0] with [7:3]=0.
  - Transfer of byte 15 increments `vec_count` and returns to LOAD.
- `m_data`/`m_last` hold stable while `m_valid`&&!`m_ready`.
- `s_data` is ignored outside LOAD; `resp_in` is ignored except at the capture edge.

## Timing
- Reset values: `s_ready`=1 (once in LOAD), `m_valid`=0, `m_data`=0, `m_last`=0, `busy`=0, `vec_out`=0, `vec_count`=0. Shadow, counters and byte indices are 0.
- `vec_out` updates at edge E0, the edge that accepts byte 22.
- `resp_in` is sampled at edge E0+SETTLE_CYCLES; `m_valid` rises in the following cycle.
- Minimum per-vector cost: 23 + SETTLE_CYCLES + 16 cycles, with no stalls.
- One byte per cycle maximum on each stream. No combinational path from `s_valid`/`m_ready` to any output.
- `s_ready` drops in the cycle after byte 22 is accepted. Input and output phases never overlap.
- Reset mid-operation:
  - Immediately returns to LOAD with all outputs at reset values; the partial vector is discarded.
  - First byte after `rst_n` rises is byte 0.

## Structure
- Package `c5315_harness_pkg` holds:
  - `IN_W`/`OUT_W` defaults
  - `IN_BYTES`, `OUT_BYTES`
  - index widths via $clog2
  - state enum `harness_state_t` {LOAD, SETTLE, UNLOAD}
- Single module; no sub-module needed. The top level instantiates `wrapper` alongside and connects `vec_out`→`in_val` and `out_val`→`resp_in`.

## Test plan
- Reset check: assert `rst_n`=0 → all outputs at reset values; after release `s_ready`=1, `busy`=0.
- All-ones load: send 23 bytes of 0xFF with `resp_in`=0 → `vec_out` = 178 ones. Then 16 bytes of 0x00 with `m_last` only on the 16th; `vec_count`=1.
- Byte ordering: send bytes 0x00..0x16 with `resp_in`=123'h5A5…5 pattern → `vec_out`[7:0]=0x00 and `vec_out`[177:176]=2'b10. Response bytes match `resp_in`[8i+7:8i]; byte 15 upper 5 bits are 0.
- Settle timing: SETTLE_CYCLES=1 and =4. Change `resp_in` each cycle → captured value equals `resp_in` at edge E0+SETTLE_CYCLES exactly.
- Backpressure/gaps:
  - Random `s_valid` gaps and `m_ready` toggling → identical results to the no-stall case.
  - `m_data` stable through stalls.
  - `vec_out` unchanged while the next vector loads, until its byte 22.
- Reset mid-UNLOAD: assert `rst_n` after 7 response bytes → `m_valid`=0 and `vec_out`=0 immediately. The next 23-byte load completes normally and `vec_count`=1.
